// File: rtl/ufm_pkg.sv
// Shared definitions for the UFM reader arbiter: FSM encoding, UFM window
// constants and the default reader address width.
package ufm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int UFM_ADDR_W_DEFAULT = 15;
  localparam int UFM_PAGE_BYTES     = 16;

  // MachXO2-7000: the UFM window starts at page 2042 and spans four pages.
  localparam int XO2_7000_UFM_PAGE  = 2042;
  localparam int XO2_7000_UFM_BYTES = 64;
  localparam int XO2_7000_ADDR_LO   = XO2_7000_UFM_PAGE * UFM_PAGE_BYTES;
  localparam int XO2_7000_ADDR_HI   = XO2_7000_ADDR_LO + XO2_7000_UFM_BYTES - 1;

endpackage

// File: rtl/ufm_read_arbiter_rr_pick.sv
// Combinational round-robin picker: scans i_req from i_ptr upwards, wrapping,
// and returns the first set bit as a one-hot grant plus its index.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  int j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      // i_ptr < N and k < N, so one subtraction is enough to wrap.
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_valid && i_req[j]) begin
        o_valid  = 1'b1;
        o_idx    = PW'(j);
        o_gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ufm_read_arbiter.sv
// Round-robin arbiter sharing the single UFM reader port among NUM_REQ requesters,
// with one outstanding read, UFM window range check and a lost-response watchdog.
//
// Reader handshake: a read is accepted in the cycle where rdr_rd && !rdr_stall;
// rdr_rd and rdr_addr are held unchanged until then. The response is a single
// rdr_valid cycle, honoured only while waiting; each requester holds req_rd and
// its address until it sees its one-cycle req_ack (req_err qualifies it).
module ufm_read_arbiter
  import ufm_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = UFM_ADDR_W_DEFAULT,
  parameter int ADDR_LO = XO2_7000_ADDR_LO,
  parameter int ADDR_HI = XO2_7000_ADDR_HI,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      req_err,
  output logic [7:0]                req_data,
  output logic [ADDR_W-1:0]         rdr_addr,
  output logic                      rdr_rd,
  input  logic                      rdr_stall,
  input  logic [7:0]                rdr_data,
  input  logic                      rdr_valid,
  output logic [1:0]                dbg_state
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LO_A   = ADDR_W'(ADDR_LO);
  localparam logic [ADDR_W-1:0] HI_A   = ADDR_W'(ADDR_HI);
  // Last WAIT cycle: a timeout decided here acks exactly TIMEOUT cycles after accept.
  localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT - 2);

  state_t               r_state;
  state_t               w_next;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_gnt;
  logic [NUM_REQ-1:0]   r_gnt_oh;
  logic [ADDR_W-1:0]    r_addr;
  logic [TW-1:0]        r_timer;

  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [PW-1:0]        w_pick_idx;
  logic                 w_pick_valid;
  logic [ADDR_W-1:0]    w_pick_addr;
  logic                 w_in_range;

  logic                 w_load;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_err;
  logic [7:0]           w_data;
  logic [PW-1:0]        w_done_idx;
  logic [NUM_REQ-1:0]   w_done_oh;
  logic [PW-1:0]        w_ptr_next;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_pick (
    .i_req   (req_rd),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_pick_addr = req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
  assign w_in_range  = (w_pick_addr >= LO_A) && (w_pick_addr <= HI_A);
  assign w_ptr_next  = (w_done_idx == PW'(NUM_REQ - 1)) ? '0 : w_done_idx + PW'(1);

  assign rdr_rd    = (r_state == ST_ISSUE);
  assign rdr_addr  = r_addr;
  assign dbg_state = r_state;

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_accept   = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_data     = '0;
    w_done_idx = r_gnt;
    w_done_oh  = r_gnt_oh;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_done_idx = w_pick_idx;
          w_done_oh  = w_pick_oh;
          if (w_in_range) begin
            w_load = 1'b1;
            w_next = ST_ISSUE;
          end else begin
            w_done = 1'b1;
            w_err  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (!rdr_stall) begin
          w_accept = 1'b1;
          w_next   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response arriving on the last cycle beats the watchdog.
        if (rdr_valid) begin
          w_done = 1'b1;
          w_data = rdr_data;
          w_next = ST_IDLE;
        end else if (r_timer == T_LAST) begin
          w_done = 1'b1;
          w_err  = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_gnt_oh <= '0;
      r_addr   <= '0;
      r_timer  <= '0;
      req_ack  <= '0;
      req_err  <= 1'b0;
      req_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_gnt    <= w_pick_idx;
        r_gnt_oh <= w_pick_oh;
        r_addr   <= w_pick_addr;
      end
      if (w_accept) begin
        r_timer <= '0;
      end else if (r_state == ST_WAIT) begin
        r_timer <= r_timer + TW'(1);
      end
      if (w_done) begin
        r_ptr <= w_ptr_next;
      end
      req_ack  <= w_done ? w_done_oh : '0;
      req_err  <= w_err;
      req_data <= w_data;
    end
  end

endmodule
